dcache_controller: RTL and testbench

Direct-mapped, write-back, write-allocate data cache between the pipeline's MEM stage and a slow, line-wide off-chip data memory. Sits directly downstream of the EX/MEM pipeline register, replacing the single-cycle data memory. Serves hits in the same cycle. Holds `cpu_stall_o` high while a miss is refilled, and the pipeline freezes for that time. Runs a request/acknowledge handshake to external memory for write-back and refill.

---
 rtl/dcache_pkg.sv | 30 +++
 rtl/dcache_array.sv | 67 ++++++
 rtl/dcache_controller.sv | 121 ++++++++++++
 tb/tb_dcache_controller.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Purpose: shared types, field widths and address-split helpers for the data cache.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package dcache_pkg;

  localparam int OFF_W  = 5;                      // byte offset within a 32-byte line
  localparam int IDX_W  = 4;                      // 16 lines
  localparam int TAG_W  = 32 - IDX_W - OFF_W;     // 23
  localparam int LINE_W = 8 << OFF_W;             // 256-bit line
  localparam int WSEL_W = OFF_W - 2;              // word select within a line

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WB    = 2'd1,
    ST_ALLOC = 2'd2
  } state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
    return a[31 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [WSEL_W-1:0] addr_wsel(input logic [31:0] a);
    return a[2 +: WSEL_W];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Purpose: valid/dirty/tag/data storage for the direct-mapped cache, one shared index.
// Latency: combinational read; writes land on the next rising edge.
// Backpressure: none; the controller sequences all writes.
module dcache_array
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic              valid_o,
  output logic              dirty_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [LINE_W-1:0] line_o,
  input  logic              line_we_i,
  input  logic [TAG_W-1:0]  line_tag_i,
  input  logic [LINE_W-1:0] line_dat_i,
  input  logic              word_we_i,
  input  logic [WSEL_W-1:0] wsel_i,
  input  logic [31:0]       word_dat_i,
  input  logic              dirty_clr_i
);

  localparam int N = 1 << IDX_W;

  logic [N-1:0]      valid_q, valid_d;
  logic [N-1:0]      dirty_q, dirty_d;
  logic [TAG_W-1:0]  tag_q  [N];
  logic [TAG_W-1:0]  tag_d  [N];
  logic [LINE_W-1:0] data_q [N];
  logic [LINE_W-1:0] data_d [N];

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign line_o  = data_q[idx_i];

  // Next-state of the arrays: reset clears only status bits; a refill beats a word store.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (!rst_i) begin
      valid_d = '0;
      dirty_d = '0;
    end else if (line_we_i) begin
      data_d[idx_i]  = line_dat_i;
      tag_d[idx_i]   = line_tag_i;
      valid_d[idx_i] = 1'b1;
      dirty_d[idx_i] = 1'b0;
    end else if (word_we_i) begin
      data_d[idx_i][{wsel_i, 5'b00000} +: 32] = word_dat_i;
      dirty_d[idx_i] = 1'b1;
    end else if (dirty_clr_i) begin
      dirty_d[idx_i] = 1'b0;
    end
  end

  // Register the arrays; tag and data contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    valid_q <= valid_d;
    dirty_q <= dirty_d;
    tag_q   <= tag_d;
    data_q  <= data_d;
  end

endmodule

// File: rtl/dcache_controller.sv
// Purpose: direct-mapped write-back/write-allocate D-cache between MEM stage and line memory.
// Latency: hits complete in the request cycle; misses stall 1 + (W) + N cycles.
// Backpressure: cpu_stall_o freezes the pipeline; memory side waits for mem_ack_i.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int LINES      = 16,
  parameter int LINE_BYTES = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  // The address split in the package is fixed to the default geometry.
  if (LINES != (1 << IDX_W) || LINE_BYTES != (1 << OFF_W)) begin : g_geom_check
    $error("dcache_controller: geometry must match dcache_pkg (16 lines of 32 bytes)");
  end

  state_t state_q, state_d;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WSEL_W-1:0] req_wsel;
  logic              unused_byte_bits;

  logic              arr_valid, arr_dirty;
  logic [TAG_W-1:0]  arr_tag;
  logic [LINE_W-1:0] arr_line;
  logic              line_we, word_we, dirty_clr;
  logic              hit;

  assign req_tag          = addr_tag(cpu_addr_i);
  assign req_idx          = addr_idx(cpu_addr_i);
  assign req_wsel         = addr_wsel(cpu_addr_i);
  assign unused_byte_bits = ^cpu_addr_i[1:0];

  dcache_array u_array (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .idx_i       (req_idx),
    .valid_o     (arr_valid),
    .dirty_o     (arr_dirty),
    .tag_o       (arr_tag),
    .line_o      (arr_line),
    .line_we_i   (line_we),
    .line_tag_i  (req_tag),
    .line_dat_i  (mem_data_i),
    .word_we_i   (word_we),
    .wsel_i      (req_wsel),
    .word_dat_i  (cpu_data_i),
    .dirty_clr_i (dirty_clr)
  );

  assign hit        = cpu_req_i & arr_valid & (arr_tag == req_tag);
  assign cpu_data_o = hit ? arr_line[{req_wsel, 5'b00000} +: 32] : 32'd0;

  // Next state, array write strobes and all state-decoded outputs.
  always_comb begin
    state_d     = state_q;
    line_we     = 1'b0;
    word_we     = 1'b0;
    dirty_clr   = 1'b0;
    cpu_stall_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_data_o  = '0;
    unique case (state_q)
      ST_IDLE: begin
        cpu_stall_o = cpu_req_i & ~hit;
        if (cpu_req_i && !hit) begin
          state_d = arr_dirty ? ST_WB : ST_ALLOC;
        end else if (hit && cpu_we_i) begin
          word_we = 1'b1;
        end
      end
      ST_WB: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {arr_tag, req_idx, {OFF_W{1'b0}}};
        mem_data_o  = arr_line;
        if (mem_ack_i) begin
          dirty_clr = 1'b1;
          state_d   = ST_ALLOC;
        end
      end
      ST_ALLOC: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_addr_o  = {req_tag, req_idx, {OFF_W{1'b0}}};
        if (mem_ack_i) begin
          line_we = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // The pipeline must not be frozen while the whole core is being reset.
    if (!rst_i) cpu_stall_o = 1'b0;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

endmodule

// File: tb/tb_dcache_controller.sv
module tb_dcache_controller;

  logic         clk_i;
  logic         rst_i;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  int errors = 0;
  int checks = 0;
  int ack_lat = 3;
  int inject_req = 0;

  // Backing line store (memory side) and flat word-level reference of CPU-visible data.
  logic [255:0] backing [logic [31:0]];
  logic [31:0]  ref_mem [logic [31:0]];
  logic [31:0]  exp_q [$];
  logic [31:0]  wb_addr_log [$];
  logic [255:0] wb_data_log [$];

  dcache_controller dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_data_i  (cpu_data_i),
    .cpu_data_o  (cpu_data_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_data_i  (mem_data_i),
    .mem_ack_i   (mem_ack_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic logic [31:0] dflt_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [255:0] dflt_line(input logic [31:0] la);
    logic [255:0] l;
    l = '0;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = dflt_word(la + 32'(i * 4));
    return l;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (ref_mem.exists(wa)) return ref_mem[wa];
    return dflt_word(wa);
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory responder: acks after ack_lat cycles in each request state, or a one-off spurious ack.
  initial begin
    int cnt;
    int inject_seen;
    logic [31:0] la;
    cnt = 0;
    inject_seen = 0;
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      mem_ack_i = 1'b0;
      if (inject_req != inject_seen) begin
        inject_seen = inject_req;
        mem_ack_i = 1'b1;
        mem_data_i = {8{32'hBAD0_BAD0}};
        cnt = 0;
      end else if (mem_req_o === 1'b1 && rst_i === 1'b1) begin
        cnt++;
        if (cnt >= ack_lat) begin
          cnt = 0;
          la = mem_addr_o;
          mem_ack_i = 1'b1;
          if (mem_we_o === 1'b1) begin
            backing[la] = mem_data_o;
            wb_addr_log.push_back(la);
            wb_data_log.push_back(mem_data_o);
          end else begin
            if (!backing.exists(la)) backing[la] = dflt_line(la);
            mem_data_i = backing[la];
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // One CPU access: hold the request until stall drops, then check stall length and load data.
  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input int exp_stall, input string tag);
    int stalls;
    logic [31:0] exp;
    @(negedge clk_i);
    cpu_req_i = 1'b1;
    cpu_we_i = we;
    cpu_addr_i = a;
    cpu_data_i = d;
    if (!we) exp_q.push_back(ref_rd(a));
    else ref_mem[{a[31:2], 2'b00}] = d;
    #1;
    stalls = 0;
    while (cpu_stall_o === 1'b1 && stalls < 200) begin
      stalls++;
      @(negedge clk_i);
      #1;
    end
    check32({tag, "_stall"}, 32'(stalls), 32'(exp_stall));
    if (!we) begin
      exp = exp_q.pop_front();
      check32({tag, "_data"}, cpu_data_o, exp);
    end
    @(posedge clk_i);
    #2;
    cpu_req_i = 1'b0;
    cpu_we_i = 1'b0;
  endtask

  initial begin
    logic [31:0]  wa;
    logic [255:0] wl;
    rst_i = 1'b0;
    cpu_req_i = 1'b1;
    cpu_we_i = 1'b0;
    cpu_addr_i = 32'h0000_0040;
    cpu_data_i = '0;
    wl = dflt_line(32'h0000_0040);
    wl[95:64] = 32'hDEAD_BEEF;
    backing[32'h0000_0040] = wl;
    ref_mem[32'h0000_0048] = 32'hDEAD_BEEF;

    // Reset state: stall forced low, no memory traffic, no hit data.
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    check32("rst_stall", 32'(cpu_stall_o), 32'd0);
    check32("rst_mem_req", 32'(mem_req_o), 32'd0);
    check32("rst_cpu_data", cpu_data_o, 32'd0);
    cpu_req_i = 1'b0;
    rst_i = 1'b1;

    // Cold miss, clean allocate with a 3-cycle memory.
    ack_lat = 3;
    access(1'b0, 32'h0000_0040, 32'd0, 4, "cold_ld");
    access(1'b1, 32'h0000_0044, 32'h1234_5678, 0, "st_hit");
    access(1'b0, 32'h0000_0044, 32'd0, 0, "ld_after_st");

    // Dirty conflict miss: write back 0x40 then refill 0x240.
    ack_lat = 2;
    access(1'b0, 32'h0000_0240, 32'd0, 5, "dirty_miss");
    check32("wb_count", 32'(wb_addr_log.size()), 32'd1);
    if (wb_addr_log.size() > 0) begin
      wa = wb_addr_log.pop_front();
      wl = wb_data_log.pop_front();
      check32("wb_addr", wa, 32'h0000_0040);
      check32("wb_word1", wl[63:32], ref_rd(32'h0000_0044));
      check32("wb_word2", wl[95:64], ref_rd(32'h0000_0048));
    end

    // Reset in the second ALLOC cycle of a clean miss to 0x440.
    ack_lat = 10;
    @(negedge clk_i);
    cpu_req_i = 1'b1;
    cpu_we_i = 1'b0;
    cpu_addr_i = 32'h0000_0440;
    #1;
    check32("rst_t_detect_stall", 32'(cpu_stall_o), 32'd1);
    @(negedge clk_i);
    #1;
    check32("rst_t_alloc_req", 32'(mem_req_o), 32'd1);
    check32("rst_t_alloc_we", 32'(mem_we_o), 32'd0);
    check32("rst_t_alloc_addr", mem_addr_o, 32'h0000_0440);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check32("rst_t_stall_forced", 32'(cpu_stall_o), 32'd0);
    @(posedge clk_i);
    #2;
    check32("rst_t_req_drop", 32'(mem_req_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    cpu_req_i = 1'b0;

    // Valid bits were cleared, so 0x240 must miss again (clean, no write-back).
    ack_lat = 2;
    access(1'b0, 32'h0000_0240, 32'd0, 3, "post_rst_miss");
    check32("post_rst_no_wb", 32'(wb_addr_log.size()), 32'd0);

    // Hit sweep over every word of the refilled line.
    for (int i = 0; i < 8; i++)
      access(1'b0, 32'h0000_0240 + 32'(i * 4), 32'd0, 0, $sformatf("sweep%0d", i));

    // Spurious ack while idle: no state change and no array write.
    @(negedge clk_i);
    inject_req++;
    repeat (2) @(negedge clk_i);
    #1;
    check32("spur_req", 32'(mem_req_o), 32'd0);
    check32("spur_stall", 32'(cpu_stall_o), 32'd0);
    check32("spur_data_idle", cpu_data_o, 32'd0);
    access(1'b0, 32'h0000_0244, 32'd0, 0, "spur_hit");
    access(1'b0, 32'h0000_0258, 32'd0, 0, "spur_hit2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish (errors=%0d checks=%0d)", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
